instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/mips_pkg.sv | 33 +++
 rtl/instr_fetch_unit_if.sv | 29 ++
 rtl/pc_next_sel.sv | 33 +++
 rtl/instr_fetch_unit.sv | 139 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the instruction fetch slice.
// Contents:
//   pc_src_e      : next-PC select encodings (sequential / branch / jump / jr)
//   fetch_state_e : fetch FSM state encoding
//   NOP           : instruction word presented when FetchValid is low
//   WORD_BYTES    : sequential PC increment
//   word_align()  : clears the byte-offset bits of an address
package mips_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_JR     = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_FETCH   = 2'b01,
    S_HOLD    = 2'b10,
    S_DISCARD = 2'b11
  } fetch_state_e;

  localparam logic [31:0] NOP        = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  // Instruction addresses are always word aligned; any low bits supplied
  // by a register or a target computation are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if -- instruction memory request/response bus.
// Signals:
//   imem_req   : fetch unit requests a word at imem_addr
//   imem_addr  : word address of the request
//   imem_ready : one-cycle pulse, imem_rdata valid in that cycle
//   imem_rdata : returned instruction word
// Modports:
//   master : fetch unit side (drives req/addr)
//   slave  : memory side (drives ready/rdata)
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel -- combinational next-PC selection.
// Ports:
//   pc            : current PC
//   pc_src        : 00 sequential, 01 branch, 10 jump, 11 jr
//   branch_target : branch destination
//   jump_field    : 26-bit j/jal instruction index
//   pc_upper      : bits [31:28] of the jump's PC+4
//   jr_target     : register value for jr
//   next_pc       : selected, word-aligned next PC
module pc_next_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [25:0] jump_field,
  input  logic [3:0]  pc_upper,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc
);

  always_comb begin
    // Sequential wraps naturally modulo 2^32.
    next_pc = word_align(pc + WORD_BYTES);
    case (pc_src_e'(pc_src))
      PCSRC_BRANCH: next_pc = word_align(branch_target);
      PCSRC_JUMP:   next_pc = {pc_upper, jump_field, 2'b00};
      PCSRC_JR:     next_pc = word_align(jr_target);
      default:      ;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit -- IF stage: owns the PC, issues instruction memory
// requests and registers the fetched word into the IF/ID outputs.
// Ports:
//   clk          : clock, all state on rising edge
//   Reset_L      : asynchronous active-low reset
//   PCWrite      : downstream accepts; 0 stalls and holds outputs
//   PCSrc        : next-PC select (00 seq, 01 branch, 10 jump, 11 jr)
//   BranchTarget : branch destination
//   JumpField    : j/jal instruction index
//   PCUpper_ID   : bits [31:28] of the jump's PC+4
//   JRTarget     : register value for jr
//   imem         : instruction memory bus (master side)
//   Instruction  : registered instruction, NOP when FetchValid=0
//   PCPlus4      : registered fetch PC + 4
//   FetchValid   : Instruction holds a real fetched word
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       Reset_L,
  input  logic                       PCWrite,
  input  logic [1:0]                 PCSrc,
  input  logic [31:0]                BranchTarget,
  input  logic [25:0]                JumpField,
  input  logic [3:0]                 PCUpper_ID,
  input  logic [31:0]                JRTarget,
  instr_fetch_unit_if.master         imem,
  output logic [31:0]                Instruction,
  output logic [31:0]                PCPlus4,
  output logic                       FetchValid
);

  fetch_state_e state_reg;
  logic [31:0]  pc_reg;
  logic [31:0]  instr_reg;
  logic [31:0]  pc_plus4_reg;
  logic         valid_reg;
  logic         req_reg;

  logic [31:0]  next_pc;
  logic [31:0]  pc_seq;
  logic         redirect;

  pc_next_sel u_pc_next_sel (
    .pc            (pc_reg),
    .pc_src        (PCSrc),
    .branch_target (BranchTarget),
    .jump_field    (JumpField),
    .pc_upper      (PCUpper_ID),
    .jr_target     (JRTarget),
    .next_pc       (next_pc)
  );

  assign pc_seq   = pc_reg + WORD_BYTES;
  // PCSrc only matters when the stage is allowed to advance.
  assign redirect = PCWrite && (PCSrc != PCSRC_SEQ);

  always_ff @(posedge clk or negedge Reset_L) begin
    if (!Reset_L) begin
      state_reg    <= S_IDLE;
      pc_reg       <= RESET_PC;
      instr_reg    <= NOP;
      pc_plus4_reg <= 32'h0;
      valid_reg    <= 1'b0;
      req_reg      <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          state_reg <= S_FETCH;
          req_reg   <= 1'b1;
        end

        S_FETCH: begin
          if (redirect) begin
            // Any word arriving now belongs to the old path and is dropped.
            // If it has not arrived yet, its eventual response must be
            // swallowed in S_DISCARD.
            pc_reg    <= next_pc;
            instr_reg <= NOP;
            valid_reg <= 1'b0;
            if (!imem.imem_ready) begin
              state_reg <= S_DISCARD;
            end
          end else if (imem.imem_ready) begin
            instr_reg    <= imem.imem_rdata;
            pc_plus4_reg <= pc_seq;
            valid_reg    <= 1'b1;
            if (PCWrite) begin
              pc_reg <= pc_seq;
            end else begin
              // Downstream stalled: park the word and stop requesting.
              state_reg <= S_HOLD;
              req_reg   <= 1'b0;
            end
          end else if (PCWrite) begin
            // Downstream consumed the previous word and nothing new is
            // available, so present a bubble.
            instr_reg <= NOP;
            valid_reg <= 1'b0;
          end
        end

        S_HOLD: begin
          // No request is outstanding here, so leaving always yields a
          // bubble; next_pc covers both the sequential and redirect cases.
          if (PCWrite) begin
            pc_reg    <= next_pc;
            instr_reg <= NOP;
            valid_reg <= 1'b0;
            state_reg <= S_FETCH;
            req_reg   <= 1'b1;
          end
        end

        S_DISCARD: begin
          if (redirect) begin
            pc_reg <= next_pc;
          end else if (imem.imem_ready) begin
            state_reg <= S_FETCH;
          end
        end

        default: begin
          state_reg <= S_IDLE;
          req_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_reg;
  assign imem.imem_addr = pc_reg;
  assign Instruction    = instr_reg;
  assign PCPlus4        = pc_plus4_reg;
  assign FetchValid     = valid_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit -- directed bench for instr_fetch_unit.
// A behavioural model tracks the expected PC and IF/ID outputs and is
// compared on every falling edge; literal checks pin key addresses.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] MAGIC    = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        Reset_L;
  logic        PCWrite;
  logic [1:0]  PCSrc;
  logic [31:0] BranchTarget;
  logic [25:0] JumpField;
  logic [3:0]  PCUpper_ID;
  logic [31:0] JRTarget;
  logic [31:0] Instruction;
  logic [31:0] PCPlus4;
  logic        FetchValid;

  int tests = 0;
  int fails = 0;

  instr_fetch_unit_if imem_bus ();

  // Memory returns a word derived from the address it is asked for.
  assign imem_bus.imem_rdata = imem_bus.imem_addr ^ MAGIC;

  instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .Reset_L      (Reset_L),
    .PCWrite      (PCWrite),
    .PCSrc        (PCSrc),
    .BranchTarget (BranchTarget),
    .JumpField    (JumpField),
    .PCUpper_ID   (PCUpper_ID),
    .JRTarget     (JRTarget),
    .imem         (imem_bus),
    .Instruction  (Instruction),
    .PCPlus4      (PCPlus4),
    .FetchValid   (FetchValid)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_instr, m_pc4, m_tgt;
  logic        m_valid, m_started, m_holding, m_dropping, m_redir;

  always_comb begin
    m_redir = PCWrite && (PCSrc != 2'b00);
    case (PCSrc)
      2'b01:   m_tgt = BranchTarget & 32'hFFFF_FFFC;
      2'b10:   m_tgt = {PCUpper_ID, JumpField, 2'b00};
      2'b11:   m_tgt = JRTarget & 32'hFFFF_FFFC;
      default: m_tgt = m_pc + 32'd4;
    endcase
  end

  always @(posedge clk or negedge Reset_L) begin
    if (!Reset_L) begin
      m_pc <= RESET_PC; m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
      m_started <= 1'b0; m_holding <= 1'b0; m_dropping <= 1'b0;
    end else if (!m_started) begin
      m_started <= 1'b1;
    end else if (m_holding) begin
      if (PCWrite) begin
        m_holding <= 1'b0; m_instr <= 32'h0; m_valid <= 1'b0; m_pc <= m_tgt;
      end
    end else if (m_dropping) begin
      if (m_redir) m_pc <= m_tgt;
      else if (imem_bus.imem_ready) m_dropping <= 1'b0;
    end else begin
      if (m_redir) begin
        m_pc <= m_tgt; m_instr <= 32'h0; m_valid <= 1'b0;
        m_dropping <= !imem_bus.imem_ready;
      end else if (imem_bus.imem_ready) begin
        m_instr <= m_pc ^ MAGIC; m_pc4 <= m_pc + 32'd4; m_valid <= 1'b1;
        if (PCWrite) m_pc <= m_pc + 32'd4;
        else m_holding <= 1'b1;
      end else if (PCWrite) begin
        m_instr <= 32'h0; m_valid <= 1'b0;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cyc_req",   32'(imem_bus.imem_req), 32'(m_started && !m_holding));
    check("cyc_addr",  imem_bus.imem_addr, m_pc);
    check("cyc_instr", Instruction, m_instr);
    check("cyc_pc4",   PCPlus4, m_pc4);
    check("cyc_valid", 32'(FetchValid), 32'(m_valid));
  end

  // One transaction = one clock with the given controls.
  task automatic tick(input logic pcw, input logic [1:0] src, input logic rdy);
    PCWrite = pcw; PCSrc = src; imem_bus.imem_ready = rdy;
    @(posedge clk); @(negedge clk);
    $display("[TB] t=%0t pcw=%b src=%b rdy=%b -> addr=%h req=%b valid=%b instr=%h pc4=%h",
             $time, pcw, src, rdy, imem_bus.imem_addr, imem_bus.imem_req,
             FetchValid, Instruction, PCPlus4);
  endtask

  task automatic lit(input string name, input logic [31:0] addr, input logic [31:0] pc4,
                     input logic valid, input logic req);
    check({name, "_addr"},  imem_bus.imem_addr, addr);
    check({name, "_pc4"},   PCPlus4, pc4);
    check({name, "_valid"}, 32'(FetchValid), 32'(valid));
    check({name, "_req"},   32'(imem_bus.imem_req), 32'(req));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin
    Reset_L = 1'b0; PCWrite = 1'b0; PCSrc = 2'b00; imem_bus.imem_ready = 1'b0;
    BranchTarget = 32'h0; JumpField = 26'h0; PCUpper_ID = 4'h0; JRTarget = 32'h0;
    repeat (2) @(negedge clk);
    lit("reset", 32'h0, 32'h0, 1'b0, 1'b0);
    check("reset_instr", Instruction, 32'h0);

    // Reset release, memory answering every cycle.
    Reset_L = 1'b1;
    tick(1'b1, 2'b00, 1'b1); lit("idle2fetch", 32'h0, 32'h0, 1'b0, 1'b1);
    tick(1'b1, 2'b00, 1'b1); lit("seq0", 32'h4, 32'h4, 1'b1, 1'b1);
    check("seq0_instr", Instruction, 32'h0000_0000 ^ MAGIC);
    tick(1'b1, 2'b00, 1'b1); lit("seq4", 32'h8, 32'h8, 1'b1, 1'b1);

    // Stall after the fetch at 0x8; PCSrc must be ignored while stalled.
    tick(1'b0, 2'b00, 1'b1); lit("stall_cap", 32'h8, 32'hC, 1'b1, 1'b0);
    BranchTarget = 32'h0000_0040;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 2'b01, 1'b0); lit("stall_hold", 32'h8, 32'hC, 1'b1, 1'b0);
      check("stall_instr", Instruction, 32'h8 ^ MAGIC);
    end
    tick(1'b1, 2'b00, 1'b0); lit("hold_release", 32'hC, 32'hC, 1'b0, 1'b1);
    tick(1'b1, 2'b00, 1'b1); lit("seqC", 32'h10, 32'h10, 1'b1, 1'b1);

    // Branch while the 0x10 fetch is unanswered.
    tick(1'b1, 2'b01, 1'b0); lit("br_discard", 32'h40, 32'h10, 1'b0, 1'b1);
    check("br_instr", Instruction, 32'h0);
    tick(1'b1, 2'b00, 1'b0); lit("discard_wait", 32'h40, 32'h10, 1'b0, 1'b1);
    tick(1'b1, 2'b00, 1'b1); lit("discard_drop", 32'h40, 32'h10, 1'b0, 1'b1);
    tick(1'b1, 2'b00, 1'b1); lit("br_fetch", 32'h44, 32'h44, 1'b1, 1'b1);
    check("br_fetch_instr", Instruction, 32'h40 ^ MAGIC);

    // Jump with data arriving in the same cycle (dropped, stay fetching).
    PCUpper_ID = 4'h1; JumpField = 26'h000_0010;
    tick(1'b1, 2'b10, 1'b1); lit("jump", 32'h1000_0040, 32'h44, 1'b0, 1'b1);
    tick(1'b1, 2'b00, 1'b1); lit("jump_fetch", 32'h1000_0044, 32'h1000_0044, 1'b1, 1'b1);

    // jr with misaligned register value.
    JRTarget = 32'h0000_0103;
    tick(1'b1, 2'b11, 1'b1); lit("jr", 32'h100, 32'h1000_0044, 1'b0, 1'b1);
    tick(1'b1, 2'b00, 1'b1); lit("jr_fetch", 32'h104, 32'h104, 1'b1, 1'b1);

    // Wrap-around at the top of the address space.
    JRTarget = 32'hFFFF_FFFC;
    tick(1'b1, 2'b11, 1'b1); lit("jr_top", 32'hFFFF_FFFC, 32'h104, 1'b0, 1'b1);
    tick(1'b1, 2'b00, 1'b1); lit("wrap", 32'h0, 32'h0, 1'b1, 1'b1);

    // Second redirect while discarding.
    BranchTarget = 32'h0000_0202;
    tick(1'b1, 2'b01, 1'b0); lit("br2", 32'h200, 32'h0, 1'b0, 1'b1);
    PCUpper_ID = 4'h0; JumpField = 26'h000_0100;
    tick(1'b1, 2'b10, 1'b0); lit("discard_redir", 32'h400, 32'h0, 1'b0, 1'b1);
    tick(1'b1, 2'b00, 1'b1); lit("discard_end", 32'h400, 32'h0, 1'b0, 1'b1);
    tick(1'b1, 2'b00, 1'b1); lit("fetch400", 32'h404, 32'h404, 1'b1, 1'b1);

    // Redirect out of the hold state.
    tick(1'b0, 2'b00, 1'b1); lit("hold404", 32'h404, 32'h408, 1'b1, 1'b0);
    BranchTarget = 32'h0000_0080;
    tick(1'b1, 2'b01, 1'b0); lit("hold_redir", 32'h80, 32'h408, 1'b0, 1'b1);
    check("hold_redir_instr", Instruction, 32'h0);

    // Fetch stall with no data: address held stable.
    tick(1'b0, 2'b01, 1'b0); lit("wait_stall", 32'h80, 32'h408, 1'b0, 1'b1);
    tick(1'b1, 2'b00, 1'b1); lit("fetch80", 32'h84, 32'h84, 1'b1, 1'b1);
    tick(1'b1, 2'b00, 1'b0); lit("bubble", 32'h84, 32'h84, 1'b0, 1'b1);

    // Asynchronous reset mid-fetch with imem_ready asserted.
    #2; imem_bus.imem_ready = 1'b1; Reset_L = 1'b0;
    #1; lit("async_rst", RESET_PC, 32'h0, 1'b0, 1'b0);
    tick(1'b1, 2'b00, 1'b1); lit("rst_hold", RESET_PC, 32'h0, 1'b0, 1'b0);
    Reset_L = 1'b1;
    tick(1'b1, 2'b00, 1'b1); lit("rst_idle", 32'h0, 32'h0, 1'b0, 1'b1);
    tick(1'b1, 2'b00, 1'b1); lit("rst_fetch", 32'h4, 32'h4, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
